// File: rtl/life_stream_if.sv
// Row stream from the life frame reader to downstream consumers (valid/ready).
interface life_stream_if #(
  parameter int WIDTH = 16,
  parameter int ROWS  = 16
);
  localparam int RW = $clog2(ROWS);

  logic [WIDTH-1:0] data;
  logic [RW-1:0]    row;
  logic             valid;
  logic             ready;
  logic             last;
  logic             changed;

  modport master (output data, row, valid, last, changed, input ready);
  modport slave  (input data, row, valid, last, changed, output ready);
endinterface

// File: rtl/life_frame_reader.sv
// Scans every row of the life array on start and streams them out with valid/ready.
// Optional per-row / per-frame change flags are built when LIFE_DIFF_FLAG_EN is defined.
module life_frame_reader #(
  parameter  int ROWS  = 16,
  parameter  int WIDTH = 16,
  localparam int RW    = $clog2(ROWS)
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [RW-1:0]    valo_selector_o,
  input  logic [WIDTH-1:0] valo_i,
  input  logic [WIDTH-1:0] valo_prev_i,
  output logic             frame_changed_o,
  life_stream_if.master    m
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_CAP, S_SEND, S_DONE} state_t;

  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  state_t           state_q, state_d;
  logic [RW-1:0]    row_q, row_d;
  logic [RW-1:0]    sel_q, sel_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [RW-1:0]    mrow_q, mrow_d;
  logic             last_q, last_d;
  logic             chg_q, chg_d;
  logic             fchg_q, fchg_d;
  logic             row_diff;

`ifdef LIFE_DIFF_FLAG_EN
  assign row_diff = (valo_i != valo_prev_i);
`else
  // Previous generation is not needed without the change flags.
  logic unused_prev;
  assign unused_prev = ^valo_prev_i;
  assign row_diff    = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      sel_q   <= '0;
      data_q  <= '0;
      mrow_q  <= '0;
      last_q  <= 1'b0;
      chg_q   <= 1'b0;
      fchg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      mrow_q  <= mrow_d;
      last_q  <= last_d;
      chg_q   <= chg_d;
      fchg_q  <= fchg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    sel_d   = sel_q;
    data_d  = data_q;
    mrow_d  = mrow_q;
    last_d  = last_q;
    chg_d   = chg_q;
    fchg_d  = fchg_q;
    unique case (state_q)
      S_IDLE: if (start_i) begin
        row_d   = '0;
        fchg_d  = 1'b0;
        state_d = S_ADDR;
      end
      // Selector is registered here so the array mux settles during CAPTURE.
      S_ADDR: begin
        sel_d   = row_q;
        state_d = S_CAP;
      end
      S_CAP: begin
        data_d  = valo_i;
        mrow_d  = row_q;
        last_d  = (row_q == LAST_ROW);
        chg_d   = row_diff;
        state_d = S_SEND;
      end
      S_SEND: if (m.ready) begin
        fchg_d = fchg_q | chg_q;
        if (row_q == LAST_ROW) begin
          state_d = S_DONE;
        end else begin
          row_d   = row_q + RW'(1);
          state_d = S_ADDR;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o          = (state_q != S_IDLE);
  assign done_o          = (state_q == S_DONE);
  assign valo_selector_o = sel_q;
  assign frame_changed_o = fchg_q;
  assign m.valid         = (state_q == S_SEND);
  assign m.data          = data_q;
  assign m.row           = mrow_q;
  assign m.last          = last_q;
  assign m.changed       = chg_q;

endmodule

// File: tb/tb_life_frame_reader.sv
// Randomised scoreboard bench for life_frame_reader with a behavioural 16x16 array model.
module tb_life_frame_reader;

`ifdef LIFE_DIFF_FLAG_EN
  localparam bit DIFF_EN = 1'b1;
`else
  localparam bit DIFF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, fc;
  logic [3:0]  sel;
  logic [15:0] valo, valo_prev;
  logic [15:0] cur [16];
  logic [15:0] prv [16];

  life_stream_if #(.WIDTH(16), .ROWS(16)) s ();

  always #5 clk = ~clk;

  assign valo      = cur[sel];
  assign valo_prev = prv[sel];

  life_frame_reader #(.ROWS(16), .WIDTH(16)) dut (
    .clk_i          (clk),
    .reset_ni       (reset_n),
    .start_i        (start),
    .busy_o         (busy),
    .done_o         (done),
    .valo_selector_o(sel),
    .valo_i         (valo),
    .valo_prev_i    (valo_prev),
    .frame_changed_o(fc),
    .m              (s)
  );

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  row;
    logic        last;
    logic        chg;
  } beat_t;

  beat_t exp_q[$];
  int errors = 0;
  int checks = 0;
  int beats  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and checks stall stability.
  bit    stall_p = 1'b0;
  beat_t held;
  always @(negedge clk) begin
    beat_t act, e;
    if (!reset_n) begin
      stall_p = 1'b0;
    end else begin
      act = {s.data, s.row, s.last, s.changed};
      if (stall_p) chk("stall_hold", {s.valid, act}, {1'b1, held});
      if (s.valid && s.ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got row %0d with empty scoreboard", s.row);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", s.data, e.data);
          chk("beat_row", s.row, e.row);
          chk("beat_last", s.last, e.last);
          chk("beat_changed", s.changed, e.chg);
          beats++;
        end
      end
      stall_p = s.valid && !s.ready;
      held    = act;
    end
  end

  // Expected frame from the array contents: each row in order, flags from plain comparison.
  function automatic logic load_expected();
    logic f = 1'b0;
    for (int r = 0; r < 16; r++) begin
      logic ch = DIFF_EN && (cur[r] != prv[r]);
      exp_q.push_back({cur[r], 4'(r), r == 15, ch});
      f |= ch;
    end
    return f;
  endfunction

  // mode 0: ready high; 1: stall 5 cycles on row 7; 2: random ready.
  task automatic run_frame(input string tag, input int mode, input bit mid_start);
    int   cyc, stalls, held5, b0;
    bit   pulsed;
    logic exp_fc;
    exp_fc = load_expected();
    b0 = beats;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 1; stalls = 0; held5 = 0; pulsed = 1'b0;
    while (cyc < 1000) begin
      start = 1'b0;
      case (mode)
        1: if (s.valid && s.row == 4'd7 && held5 < 5) begin s.ready = 1'b0; held5++; end
           else s.ready = 1'b1;
        2: s.ready = ($urandom_range(0, 3) != 0);
        default: s.ready = 1'b1;
      endcase
      if (s.valid && !s.ready) stalls++;
      if (mid_start && !pulsed && s.valid && s.row == 4'd2) begin start = 1'b1; pulsed = 1'b1; end
      @(negedge clk);
      if (done) break;
      chk({tag, "_busy"}, busy, 1'b1);
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_done_cycle"}, cyc, 49 + stalls);
    chk({tag, "_busy_at_done"}, busy, 1'b1);
    chk({tag, "_frame_changed"}, fc, exp_fc);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, done, 1'b0);
    chk({tag, "_busy_fall"}, busy, 1'b0);
    chk({tag, "_fc_hold"}, fc, exp_fc);
    chk({tag, "_sel_hold"}, sel, 4'd15);
    chk({tag, "_beats"}, beats - b0, 16);
    chk({tag, "_sb_empty"}, exp_q.size(), 0);
    if (mode == 1) chk({tag, "_stalls"}, stalls, 5);
    exp_q.delete();
    s.ready = 1'b1;
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < 16; r++) begin
      cur[r] = 16'h0101 * 16'(r);
      prv[r] = cur[r];
    end
  endtask

  initial begin
    int ndone, wcyc;
    s.ready = 1'b1;
    fill_ramp();
    // Reset held with start high must not launch a frame.
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1; start = 1'b0;
    chk("rst_outputs", {busy, done, s.valid, s.last, s.changed, fc},  6'b0);
    chk("rst_sel_row", {sel, s.row}, 8'h00);
    chk("rst_data", s.data, 16'h0000);
    repeat (5) begin
      @(posedge clk); #1;
      chk("rst_idle_busy", busy, 1'b0);
    end

    run_frame("ramp", 0, 1'b0);
    run_frame("bp", 1, 1'b0);

    fill_ramp();
    cur[9] = 16'h0010; prv[9] = 16'h0000;
    run_frame("diff", 0, 1'b0);
    fill_ramp();
    run_frame("same", 0, 1'b0);
    run_frame("midstart", 0, 1'b1);

    // Reset during SEND of row 4 aborts without done.
    void'(load_expected());
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wcyc = 0;
    while (!(s.valid && s.row == 4'd4) && wcyc < 200) begin
      @(posedge clk); #1;
      wcyc++;
    end
    chk("abort_reach_row4", wcyc < 200, 1'b1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_state", {s.valid, busy, done, fc}, 4'b0);
    chk("abort_regs", {sel, s.row, s.data}, 24'h0);
    reset_n = 1'b1;
    exp_q.delete();
    ndone = 0;
    repeat (60) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("abort_no_done", ndone, 0);

    for (int f = 0; f < 4; f++) begin
      for (int r = 0; r < 16; r++) begin
        cur[r] = 16'($urandom);
        prv[r] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : cur[r];
      end
      run_frame("rand", 2, f[0]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/life_frame_reader.md
# life_frame_reader

Read-side initiator for the 16x16 life array. On a `start` pulse it scans all 16 rows through the array's `valo_selector`/`valo`/`valo_prev` read port and streams each row out over a valid/ready handshake to downstream logic (display, UART packer, host bridge). It also raises `busy` so the top-level controller can suppress `step` and writes while a frame is being read.

## Interface
Parameters:
- `ROWS`, default 16: rows per frame. Fixed at 16 for this array; the selector is 4 bits wide.
- `WIDTH`, default 16: bits per row.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle request to read a frame. Sampled only in IDLE.
- `busy`  out  1  high from the cycle after `start` is accepted until DONE is exited. Top level gates `step` and `write_enb` with `!busy`.
- `done`  out  1  one-cycle pulse after the last row handshake.
- `valo_selector`  out  4  row address to the array. Registered.
- `valo`  in  16  current-generation row from the array. Combinational from `valo_selector`.
- `valo_prev`  in  16  previous-generation row from the array.
- `m_data`  out  16  captured current row.
- `m_row`  out  4  index of the row in `m_data`.
- `m_valid`  out  1  stream valid.
- `m_ready`  in  1  stream ready.
- `m_last`  out  1  high with `m_valid` when `m_row` is 15.
- `m_changed`  out  1  row differs from its previous generation (see Configuration).
- `frame_changed`  out  1  sticky OR of `m_changed` over the frame; valid while `done` is high.

## Operation
- **State machine:** IDLE, ADDR, CAPTURE, SEND, DONE.
- **IDLE:** `busy`=0, `m_valid`=0.
  - `start`=1 → `row`←0, `frame_changed`←0, next state ADDR.
- **ADDR:** `valo_selector`←`row`. Next state CAPTURE. This cycle lets the array's read mux settle.
- **CAPTURE:**
  - `m_data`←`valo`, `m_row`←`row`, `m_last`←(`row`==15).
  - Row-diff register updated (if enabled).
  - `m_valid`←1. Next state SEND.
- **SEND:**
  - Hold `m_data`, `m_row`, `m_last`, `m_changed`, and `m_valid`=1 stable until `m_valid && m_ready`.
  - On handshake: `m_valid`←0.
    - If `row`==15 → DONE.
    - Otherwise `row`←`row`+1 → ADDR.
  - `row` is 4 bits. The increment is never taken at 15, so no wrap occurs within a frame.
- **DONE:** `done`=1 for exactly one cycle. Next state IDLE. `busy` is 1 during DONE.
- **`start` while not in IDLE:** ignored, not queued.
- **`start` in the same cycle DONE exits:** ignored. A new frame needs `start` while the FSM is in IDLE.
- **`valo_selector` between frames:** holds its last value (15 after a full frame).

## Timing
- **Reset values** (`reset`=0 at a clock edge):
  - state IDLE.
  - `busy`, `done`, `m_valid`, `m_last`, `m_changed`, `frame_changed` = 0.
  - `valo_selector`, `m_row` = 0; `m_data` = 16'h0000.
- **Reset mid-frame:** aborts immediately. No `done` is issued and the stream is dropped; downstream must tolerate `m_valid` falling without a handshake in this case only.
- **Handshake rules:** `m_valid` never deasserts without a handshake except on reset. Data is stable while `m_valid`=1 and `m_ready`=0.
- **Per-row latency:** with `m_ready` tied high, 3 cycles per row (ADDR, CAPTURE, SEND).
  - `start` at cycle 0 → first `m_valid` at cycle 3.
  - Last handshake at cycle 48; `done` at cycle 49; `busy` falls at cycle 50.
- **Backpressure:** each stalled SEND cycle adds exactly one cycle. No row is skipped or duplicated.
- **Array stability:** `valo` is sampled only in CAPTURE. The array must be stable while `busy`=1, which the top level guarantees via the `busy` gating.

## Configuration
- **Macro:** `LIFE_DIFF_FLAG_EN`.
- **Defined:**
  - In CAPTURE, `m_changed`←(`valo` != `valo_prev`).
  - On each handshake, `frame_changed`←`frame_changed` | `m_changed`.
  - `frame_changed` holds its value after DONE until the next accepted `start`. The top level uses it to detect a still-life or extinct board.
- **Not defined:**
  - `m_changed` and `frame_changed` are tied to 0.
  - `valo_prev` is unused and no compare logic is synthesized.
  - All other behaviour and timing are identical.

## Test plan
- **Reset/idle:** hold `reset`=0 for 2 cycles with `start`=1, then release → all outputs at reset values, and no frame starts until a fresh `start` in IDLE.
- **Full frame, no stall:** array model returns row `r` as 16'h0101*`r`; `m_ready`=1; pulse `start` → 16 beats with `m_row` 0..15 and matching `m_data`; `m_last` only on row 15; `done` at cycle 49; `busy` high for cycles 1..49.
- **Backpressure:** `m_ready` low for 5 cycles on row 7 → `m_data`=16'h0707 held stable; total frame extends by exactly 5 cycles; `done` at cycle 54.
- **Diff flag** (`LIFE_DIFF_FLAG_EN` defined): `valo`==`valo_prev` on all rows except row 9 (`valo`=16'h0010, `valo_prev`=16'h0000) → `m_changed`=1 only on row 9; `frame_changed`=1 at `done`. With all rows equal → `frame_changed`=0.
- **Diff flag disabled** (`LIFE_DIFF_FLAG_EN` undefined): same stimulus as above → `m_changed` and `frame_changed` remain 0 throughout.
- **Reset mid-frame / ignored start:**
  - Assert `reset`=0 during SEND of row 4 → next cycle IDLE, `m_valid`=0, no `done`.
  - Pulse `start` during row 2 of an active frame → no restart; the frame completes normally.
